// File: rtl/sprite_draw_param.sv
// Sprite overlay stage for the VGA bus chain: draws a WIDTH x HEIGHT sprite read
// from an external synchronous ROM at a position latched once per frame.
module sprite_draw_param #(
  parameter int WIDTH  = 75,
  parameter int HEIGHT = 89,
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 4,
  parameter logic [PIX_W-1:0] TRANSP_CODE = '0,
  parameter logic [PIX_W-1:0] HI_CODE     = 4'hF,
  parameter logic [11:0] COLOR_HI = 12'hFFF,
  parameter logic [11:0] COLOR_LO = 12'hF00,
  // Bus layout, MSB first: hcount[10:0], hs, hblnk, vcount[10:0], vs, vblnk, rgb[11:0]
  localparam int VGA_BUS_SIZE = 38
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [11:0]             xpos,
  input  logic [11:0]             ypos,
  input  logic                    mirror,
  input  logic                    enable,
  input  logic [VGA_BUS_SIZE-1:0] vga_in,
  output logic [VGA_BUS_SIZE-1:0] vga_out,
  input  logic [PIX_W-1:0]        rgb_pixel,
  output logic [ADDR_W-1:0]       pixel_addr
);

  localparam int HC_MSB = 37;
  localparam int HC_LSB = 27;
  localparam int HB_BIT = 25;
  localparam int VC_MSB = 24;
  localparam int VC_LSB = 14;
  localparam int VB_BIT = 12;

  logic [11:0] xl_reg, yl_reg;
  logic        ml_reg, el_reg;
  logic        vblnk_prev_reg;

  logic [VGA_BUS_SIZE-1:0] bus1_reg, bus2_reg, vga_out_reg;
  logic                    hit1_reg, hit2_reg;
  logic [ADDR_W-1:0]       pixel_addr_reg, pixel_addr_next;

  logic [12:0] hc13, vc13, x13, y13, x_end, y_end, col, row, colm;
  logic [ADDR_W-1:0] row_a, colm_a;
  logic        hit0;
  logic        frame_latch;
  logic [11:0] rgb_next;
  logic        blank2;

  assign frame_latch = vga_in[VB_BIT] & ~vblnk_prev_reg;

  // 13-bit arithmetic keeps xl/yl near 4095 from wrapping back onto column/row 0.
  always_comb begin
    hc13  = {2'b00, vga_in[HC_MSB:HC_LSB]};
    vc13  = {2'b00, vga_in[VC_MSB:VC_LSB]};
    x13   = {1'b0, xl_reg};
    y13   = {1'b0, yl_reg};
    x_end = x13 + 13'(WIDTH);
    y_end = y13 + 13'(HEIGHT);
    hit0  = el_reg & ~vga_in[HB_BIT] & ~vga_in[VB_BIT]
          & (hc13 >= x13) & (hc13 < x_end)
          & (vc13 >= y13) & (vc13 < y_end);
    col   = hc13 - x13;
    row   = vc13 - y13;
    colm  = ml_reg ? (13'(WIDTH - 1) - col) : col;
    row_a  = ADDR_W'(row);
    colm_a = ADDR_W'(colm);
    pixel_addr_next = pixel_addr_reg;
    if (hit0) begin
      pixel_addr_next = row_a * ADDR_W'(WIDTH) + colm_a;
    end
  end

  always_comb begin
    blank2   = bus2_reg[HB_BIT] | bus2_reg[VB_BIT];
    rgb_next = bus2_reg[11:0];
    if (!blank2 && hit2_reg && (rgb_pixel != TRANSP_CODE)) begin
      rgb_next = (rgb_pixel == HI_CODE) ? COLOR_HI : COLOR_LO;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      xl_reg         <= '0;
      yl_reg         <= '0;
      ml_reg         <= 1'b0;
      el_reg         <= 1'b0;
      vblnk_prev_reg <= 1'b0;
      bus1_reg       <= '0;
      bus2_reg       <= '0;
      hit1_reg       <= 1'b0;
      hit2_reg       <= 1'b0;
      pixel_addr_reg <= '0;
      vga_out_reg    <= '0;
    end else begin
      vblnk_prev_reg <= vga_in[VB_BIT];
      if (frame_latch) begin
        xl_reg <= xpos;
        yl_reg <= ypos;
        ml_reg <= mirror;
        el_reg <= enable;
      end
      bus1_reg       <= vga_in;
      bus2_reg       <= bus1_reg;
      hit1_reg       <= hit0;
      hit2_reg       <= hit1_reg;
      pixel_addr_reg <= pixel_addr_next;
      vga_out_reg    <= {bus2_reg[VGA_BUS_SIZE-1:12], rgb_next};
    end
  end

  assign vga_out    = vga_out_reg;
  assign pixel_addr = pixel_addr_reg;

endmodule

// File: tb/tb_sprite_draw_param.sv
// Directed bench for sprite_draw_param: reset, latency, table of per-pixel
// address/colour vectors across several latched frames, and a mid-frame reset.
module tb_sprite_draw_param;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        mirror, enable;
  logic [37:0] vga_in, vga_out;
  logic [3:0]  rgb_pixel;
  logic [13:0] pixel_addr;

  int checks = 0;
  int failures = 0;

  sprite_draw_param dut (
    .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos), .mirror(mirror),
    .enable(enable), .vga_in(vga_in), .vga_out(vga_out),
    .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr)
  );

  always #5 pclk = ~pclk;

  // Synchronous ROM model: code = low nibble of the address.
  always @(posedge pclk) rgb_pixel <= pixel_addr[3:0];

  typedef struct {
    logic        latch;
    logic [11:0] x;
    logic [11:0] y;
    logic        m;
    logic        e;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hb;
    logic [11:0] rgb_in;
    logic        chk_a;
    logic [13:0] addr;
    logic [11:0] rgb_exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [37:0] mk(input logic [10:0] hc, input logic hb,
                                     input logic [10:0] vc, input logic vb,
                                     input logic [11:0] rgb);
    return {hc, 1'b0, hb, vc, 1'b0, vb, rgb};
  endfunction

  function automatic vec_t mv(input logic latch, input int x, input int y,
                              input logic m, input logic e, input int hc,
                              input int vc, input logic hb, input logic [11:0] rgb_in,
                              input logic chk_a, input int addr, input logic [11:0] rgb_exp);
    vec_t v;
    v.latch = latch; v.x = 12'(x); v.y = 12'(y); v.m = m; v.e = e;
    v.hc = 11'(hc); v.vc = 11'(vc); v.hb = hb; v.rgb_in = rgb_in;
    v.chk_a = chk_a; v.addr = 14'(addr); v.rgb_exp = rgb_exp;
    return v;
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic new_frame();
    vga_in = mk(0, 0, 0, 0, 0);
    tick();
    vga_in = mk(0, 1, 0, 1, 0);
    tick();
    tick();
    vga_in = mk(0, 0, 0, 0, 0);
  endtask

  logic [37:0] hist [0:11];

  initial begin
    rst = 1'b1; xpos = '0; ypos = '0; mirror = 1'b0; enable = 1'b0;
    vga_in = '0;

    // Reset with random bus activity
    for (int i = 0; i < 5; i++) begin
      vga_in = 38'({$urandom, $urandom});
      tick();
      check($sformatf("reset_out%0d", i), vga_out, '0);
      check($sformatf("reset_addr%0d", i), 38'(pixel_addr), '0);
    end

    // Pass-through latency with the sprite disabled
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      hist[i] = 38'({$urandom, $urandom});
      vga_in = hist[i];
      tick();
      if (i >= 2) check($sformatf("latency%0d", i), vga_out, hist[i-2]);
    end

    //            latch x    y   m    e    hc    vc   hb   rgb_in    chk  addr  rgb_exp
    tbl.push_back(mv(1, 100, 50, 0, 1, 100,  50, 0, 12'h0A1, 1, 0,    12'h0A1));
    tbl.push_back(mv(0, 100, 50, 0, 1, 174,  50, 0, 12'h0A2, 1, 74,   12'hF00));
    tbl.push_back(mv(0, 100, 50, 0, 1, 100,  51, 0, 12'h0A3, 1, 75,   12'hF00));
    tbl.push_back(mv(0, 100, 50, 0, 1, 174, 138, 0, 12'h0A4, 1, 6674, 12'hF00));
    tbl.push_back(mv(0, 100, 50, 0, 1, 115,  50, 0, 12'h0A5, 1, 15,   12'hFFF));
    tbl.push_back(mv(0, 100, 50, 0, 1,  99,  50, 0, 12'h0A6, 0, 0,    12'h0A6));
    tbl.push_back(mv(0, 100, 50, 0, 1, 175,  50, 0, 12'h0A7, 0, 0,    12'h0A7));
    tbl.push_back(mv(0, 100, 50, 0, 1, 100, 139, 0, 12'h0A8, 0, 0,    12'h0A8));
    tbl.push_back(mv(1, 100, 50, 1, 1, 100,  50, 0, 12'h0B1, 1, 74,   12'hF00));
    tbl.push_back(mv(0, 100, 50, 1, 1, 174,  50, 0, 12'h0B2, 1, 0,    12'h0B2));
    tbl.push_back(mv(0, 100, 50, 1, 1, 159,  50, 0, 12'h0B3, 1, 15,   12'hFFF));
    tbl.push_back(mv(0, 100, 50, 1, 1, 160,  50, 0, 12'h0B4, 1, 14,   12'hF00));
    tbl.push_back(mv(1, 100, 50, 0, 1, 115,  50, 0, 12'h0C1, 1, 15,   12'hFFF));
    tbl.push_back(mv(0, 300, 50, 0, 1, 115,  50, 0, 12'h0C2, 1, 15,   12'hFFF));
    tbl.push_back(mv(0, 300, 50, 0, 1, 315,  50, 0, 12'h0C3, 0, 0,    12'h0C3));
    tbl.push_back(mv(1, 300, 50, 0, 1, 115,  50, 0, 12'h0C4, 0, 0,    12'h0C4));
    tbl.push_back(mv(0, 300, 50, 0, 1, 315,  50, 0, 12'h0C5, 1, 15,   12'hFFF));
    tbl.push_back(mv(1, 100, 50, 0, 0, 115,  50, 0, 12'h0D1, 0, 0,    12'h0D1));
    tbl.push_back(mv(0, 100, 50, 0, 0, 100,  50, 0, 12'h0D2, 0, 0,    12'h0D2));
    tbl.push_back(mv(1, 4090, 50, 0, 1,  0,  50, 0, 12'h0E1, 0, 0,    12'h0E1));
    tbl.push_back(mv(0, 4090, 50, 0, 1,  5,  50, 0, 12'h0E2, 0, 0,    12'h0E2));
    tbl.push_back(mv(0, 4090, 50, 0, 1, 2047, 50, 0, 12'h0E3, 0, 0,   12'h0E3));
    tbl.push_back(mv(1, 600, 50, 0, 1, 615,  50, 0, 12'h0F1, 1, 15,   12'hFFF));
    tbl.push_back(mv(0, 600, 50, 0, 1, 639,  51, 0, 12'h0F2, 1, 114,  12'hF00));
    tbl.push_back(mv(0, 600, 50, 0, 1, 640,  51, 1, 12'h0F3, 1, 114,  12'h0F3));
    tbl.push_back(mv(0, 600, 50, 0, 1, 600,  52, 0, 12'h0F4, 1, 150,  12'hF00));

    foreach (tbl[i]) begin
      xpos = tbl[i].x; ypos = tbl[i].y; mirror = tbl[i].m; enable = tbl[i].e;
      if (tbl[i].latch) new_frame();
      vga_in = mk(tbl[i].hc, tbl[i].hb, tbl[i].vc, 1'b0, tbl[i].rgb_in);
      tick();
      if (tbl[i].chk_a)
        check($sformatf("vec%0d_addr(%0d,%0d)", i, tbl[i].hc, tbl[i].vc),
              38'(pixel_addr), 38'(tbl[i].addr));
      tick();
      tick();
      check($sformatf("vec%0d_out(%0d,%0d)", i, tbl[i].hc, tbl[i].vc),
            vga_out, {vga_in[37:12], tbl[i].rgb_exp});
    end

    // Reset mid-frame while the sprite is being drawn at x=600
    vga_in = mk(615, 0, 50, 0, 12'h111);
    tick();
    rst = 1'b1;
    tick();
    check("midreset_out", vga_out, '0);
    check("midreset_addr", 38'(pixel_addr), '0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("post_reset_passthru", vga_out, mk(615, 0, 50, 0, 12'h111));
    check("post_reset_addr", 38'(pixel_addr), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
